// File: rtl/note_pkg.sv
// note_pkg: shared state, chart entry and geometry constants for the note spawner and rectangle pool
package note_pkg;
  localparam int DELAY_W = 8;
  localparam int LANE_W = 2;
  localparam int ENTRY_W = 1 + LANE_W + DELAY_W;
  localparam int NOTE_Y_W = 13;
  localparam int NOTE_RETIRE_Y = 480;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SPAWN, S_DONE} state_t;
  typedef struct packed {
    logic end_mark;
    logic [LANE_W-1:0] lane;
    logic [DELAY_W-1:0] delay;
  } chart_entry_t;
endpackage

// File: rtl/note_spawner_alloc.sv
// slot_alloc: combinational lowest-index free slot priority encoder
//   i_active     occupied slot mask
//   o_grant      one-hot lowest free slot, all zero when every slot is occupied
//   o_none_free  every slot is occupied
module slot_alloc #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_active,
  output logic [N-1:0] o_grant,
  output logic         o_none_free
);
  // adding one ripples through the trailing ones and lands on the lowest zero
  assign o_grant = ~i_active & (i_active + N'(1));
  assign o_none_free = &i_active;
endmodule

// File: rtl/note_spawner.sv
// note_spawner: plays a chart ROM, spawning falling rectangles into a pool of slots and retiring them
//   Clk, Reset   clock, asynchronous active-low reset
//   frame_tick   one pulse per video frame, paces the entry delay
//   start        begins playback from address 0 (only honoured when idle)
//   chart_addr   ROM address, chart_data combinational ROM word {end, lane, delay}
//   slot_y       current Y of every rectangle, slot_load one-cycle reload pulse per slot
//   startY       constant spawn Y, slot_active / slot_lane per-slot occupancy and lane
//   drop_count   saturating count of spawns lost to a full pool, busy high unless idle
module note_spawner
  import note_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int CHART_DEPTH = 64,
  parameter int Y_W = NOTE_Y_W,
  parameter int SPAWN_Y = 0,
  parameter int RETIRE_Y = NOTE_RETIRE_Y
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            frame_tick,
  input  logic                            start,
  output logic [$clog2(CHART_DEPTH)-1:0]  chart_addr,
  input  logic [ENTRY_W-1:0]              chart_data,
  input  logic [NUM_SLOTS*Y_W-1:0]        slot_y,
  output logic [NUM_SLOTS-1:0]            slot_load,
  output logic [Y_W-1:0]                  startY,
  output logic [NUM_SLOTS-1:0]            slot_active,
  output logic [NUM_SLOTS*LANE_W-1:0]     slot_lane,
  output logic [7:0]                      drop_count,
  output logic                            busy
);
  localparam int AW = $clog2(CHART_DEPTH);
  localparam logic [AW-1:0] LAST = AW'(CHART_DEPTH - 1);
  state_t r_state, w_next;
  chart_entry_t w_entry;
  logic [AW-1:0] r_addr;
  logic [DELAY_W-1:0] r_delay;
  logic [LANE_W-1:0] r_lane;
  logic [NUM_SLOTS-1:0] r_active, r_load, w_grant, w_retire, w_claim;
  logic [NUM_SLOTS*LANE_W-1:0] r_slot_lane;
  logic [7:0] r_drop;
  logic r_busy, w_none_free, w_spawn;
  assign w_entry = chart_entry_t'(chart_data);
  slot_alloc #(.N(NUM_SLOTS)) u_alloc (
    .i_active   (r_active),
    .o_grant    (w_grant),
    .o_none_free(w_none_free)
  );
  // a slot being loaded this cycle still carries the old rectangle's Y, so it is never retired
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_retire
    assign w_retire[i] = r_active[i] & ~r_load[i] & (slot_y[i*Y_W +: Y_W] >= Y_W'(RETIRE_Y));
  end
  // the claim is made on the edge into SPAWN so slot_load and slot_active rise during SPAWN itself
  assign w_claim = w_spawn ? w_grant : '0;
  always_comb begin
    w_next = r_state;
    w_spawn = 1'b0;
    case (r_state)
      S_IDLE:  w_next = start ? S_FETCH : S_IDLE;
      S_FETCH: w_next = w_entry.end_mark ? S_DONE : S_WAIT;
      S_WAIT: begin
        w_spawn = (r_delay == '0) || (frame_tick && r_delay == DELAY_W'(1));
        w_next = w_spawn ? S_SPAWN : S_WAIT;
      end
      S_SPAWN: w_next = (r_addr == LAST) ? S_DONE : S_FETCH;
      S_DONE:  w_next = (r_active == '0) ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_busy <= 1'b0;
      r_addr <= '0;
      r_delay <= '0;
      r_lane <= '0;
      r_active <= '0;
      r_load <= '0;
      r_slot_lane <= '0;
      r_drop <= '0;
    end else begin
      r_state <= w_next;
      r_busy <= (w_next != S_IDLE);
      r_load <= w_claim;
      r_active <= (r_active | w_claim) & ~w_retire;
      if (r_state == S_IDLE && start) begin
        r_addr <= '0;
        r_drop <= '0;
      end
      if (r_state == S_FETCH) begin
        r_delay <= w_entry.delay;
        r_lane <= w_entry.lane;
      end
      if (r_state == S_WAIT && frame_tick && r_delay != '0) r_delay <= r_delay - DELAY_W'(1);
      if (w_spawn && w_none_free && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      if (r_state == S_SPAWN && r_addr != LAST) r_addr <= r_addr + AW'(1);
      for (int k = 0; k < NUM_SLOTS; k++)
        if (w_claim[k]) r_slot_lane[k*LANE_W +: LANE_W] <= r_lane;
    end
  end
  assign chart_addr = r_addr;
  assign slot_load = r_load;
  assign startY = Y_W'(SPAWN_Y);
  assign slot_active = r_active;
  assign slot_lane = r_slot_lane;
  assign drop_count = r_drop;
  assign busy = r_busy;
endmodule

// File: tb/tb_note_spawner.sv
// tb_note_spawner: directed scenario checks for the note spawner
module tb_note_spawner;
  localparam int NS = 4;
  localparam int DEPTH = 512;
  localparam int YW = 13;
  localparam int AW = 9;
  logic Clk = 1'b0, Reset = 1'b0, frame_tick = 1'b0, start = 1'b0;
  logic [AW-1:0] chart_addr;
  logic [10:0] chart_data;
  logic [NS*YW-1:0] slot_y;
  logic [NS-1:0] slot_load, slot_active;
  logic [YW-1:0] startY;
  logic [2*NS-1:0] slot_lane;
  logic [7:0] drop_count;
  logic busy;
  logic [10:0] rom [DEPTH];
  logic [YW-1:0] yv [NS];
  int n_cmp = 0, n_bad = 0;

  note_spawner #(.NUM_SLOTS(NS), .CHART_DEPTH(DEPTH), .Y_W(YW), .SPAWN_Y(0), .RETIRE_Y(480)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start),
    .chart_addr(chart_addr), .chart_data(chart_data), .slot_y(slot_y),
    .slot_load(slot_load), .startY(startY), .slot_active(slot_active),
    .slot_lane(slot_lane), .drop_count(drop_count), .busy(busy)
  );

  always #5 Clk = ~Clk;
  assign chart_data = rom[chart_addr];
  assign slot_y = {yv[3], yv[2], yv[1], yv[0]};

  function automatic logic [10:0] ent(input logic e, input logic [1:0] l, input logic [7:0] d);
    return {e, l, d};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = ent(1'b1, 2'd0, 8'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic retire_all();
    for (int i = 0; i < NS; i++) yv[i] = 13'd480;
    step(3);
    for (int i = 0; i < NS; i++) yv[i] = 13'd0;
  endtask

  task automatic test_reset();
    clear_rom();
    for (int i = 0; i < NS; i++) yv[i] = 13'd0;
    step(2);
    n_cmp++; if ({slot_load, slot_active, slot_lane} !== 16'h0) begin n_bad++; $display("FAIL reset_slots: got %h expected 0000", {slot_load, slot_active, slot_lane}); end
    n_cmp++; if ({chart_addr, drop_count, busy} !== 18'h0) begin n_bad++; $display("FAIL reset_ctrl: addr=%h drop=%h busy=%b expected all 0", chart_addr, drop_count, busy); end
    n_cmp++; if (startY !== 13'd0) begin n_bad++; $display("FAIL reset_starty: got %0d expected 0", startY); end
    Reset = 1'b1;
    step(2);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic_chart();
    logic [NS-1:0] seen;
    clear_rom();
    rom[0] = ent(1'b0, 2'd1, 8'd2);
    rom[1] = ent(1'b0, 2'd3, 8'd0);
    pulse_start();
    n_cmp++; if (chart_addr !== 9'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL basic_fetch: addr=%0d busy=%b expected 0/1", chart_addr, busy); end
    step(3);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    seen = '0;
    repeat (9) begin
      step(1);
      seen |= slot_load;
    end
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    n_cmp++; if (seen !== 4'b0000) begin n_bad++; $display("FAIL basic_early_load: got %b expected 0000", seen); end
    n_cmp++; if (slot_load !== 4'b0001 || slot_active !== 4'b0001) begin n_bad++; $display("FAIL basic_load0: load=%b active=%b expected 0001/0001", slot_load, slot_active); end
    n_cmp++; if (slot_lane[1:0] !== 2'd1) begin n_bad++; $display("FAIL basic_lane0: got %0d expected 1", slot_lane[1:0]); end
    step(1);
    n_cmp++; if (slot_load !== 4'b0000) begin n_bad++; $display("FAIL basic_pulse_width: got %b expected 0000", slot_load); end
    step(2);
    n_cmp++; if (slot_load !== 4'b0010 || slot_lane[3:2] !== 2'd3) begin n_bad++; $display("FAIL basic_load1: load=%b lane=%0d expected 0010/3", slot_load, slot_lane[3:2]); end
    step(2);
    n_cmp++; if (busy !== 1'b1 || chart_addr !== 9'd2) begin n_bad++; $display("FAIL basic_done: busy=%b addr=%0d expected 1/2", busy, chart_addr); end
    yv[0] = 13'd480;
    yv[1] = 13'd480;
    step(1);
    n_cmp++; if (slot_active !== 4'b0000 || busy !== 1'b1) begin n_bad++; $display("FAIL basic_retire: active=%b busy=%b expected 0000/1", slot_active, busy); end
    step(1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle: got %b expected 0", busy); end
    yv[0] = 13'd0;
    yv[1] = 13'd0;
  endtask

  task automatic test_drops();
    int nl;
    clear_rom();
    for (int i = 0; i < 6; i++) rom[i] = ent(1'b0, 2'(i % 4), 8'd0);
    pulse_start();
    nl = 0;
    repeat (30) begin
      step(1);
      if (slot_load != 4'b0000) begin
        n_cmp++; if (slot_load !== 4'(1 << nl)) begin n_bad++; $display("FAIL drops_order: load=%b expected %b", slot_load, 4'(1 << nl)); end
        nl++;
      end
    end
    n_cmp++; if (nl !== 4) begin n_bad++; $display("FAIL drops_loads: got %0d expected 4", nl); end
    n_cmp++; if (drop_count !== 8'd2) begin n_bad++; $display("FAIL drops_count: got %0d expected 2", drop_count); end
    n_cmp++; if (slot_active !== 4'b1111 || slot_lane !== 8'he4) begin n_bad++; $display("FAIL drops_slots: active=%b lane=%h expected 1111/e4", slot_active, slot_lane); end
    retire_all();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drops_idle: got %b expected 0", busy); end
  endtask

  task automatic test_retire_reuse();
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = ent(1'b0, 2'd0, 8'd0);
    rom[4] = ent(1'b0, 2'd2, 8'd1);
    pulse_start();
    step(16);
    n_cmp++; if (slot_active !== 4'b1111) begin n_bad++; $display("FAIL reuse_full: got %b expected 1111", slot_active); end
    yv[2] = 13'd479;
    step(2);
    n_cmp++; if (slot_active !== 4'b1111) begin n_bad++; $display("FAIL reuse_479: got %b expected 1111", slot_active); end
    yv[2] = 13'd480;
    step(1);
    n_cmp++; if (slot_active !== 4'b1011) begin n_bad++; $display("FAIL reuse_480: got %b expected 1011", slot_active); end
    yv[2] = 13'd0;
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    n_cmp++; if (slot_load !== 4'b0100 || slot_active !== 4'b1111 || slot_lane[5:4] !== 2'd2) begin n_bad++; $display("FAIL reuse_slot2: load=%b active=%b lane=%0d expected 0100/1111/2", slot_load, slot_active, slot_lane[5:4]); end
    step(3);
    retire_all();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reuse_idle: got %b expected 0", busy); end
  endtask

  task automatic test_retire_spawn_same_cycle();
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = ent(1'b0, 2'd0, 8'd0);
    rom[4] = ent(1'b0, 2'd0, 8'd1);
    rom[5] = ent(1'b0, 2'd3, 8'd0);
    pulse_start();
    step(16);
    yv[1] = 13'd480;
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    yv[1] = 13'd0;
    n_cmp++; if (slot_load !== 4'b0000 || drop_count !== 8'd1 || slot_active !== 4'b1101) begin n_bad++; $display("FAIL same_cycle: load=%b drop=%0d active=%b expected 0000/1/1101", slot_load, drop_count, slot_active); end
    step(3);
    n_cmp++; if (slot_load !== 4'b0010 || slot_lane[3:2] !== 2'd3 || drop_count !== 8'd1) begin n_bad++; $display("FAIL same_cycle_next: load=%b lane=%0d drop=%0d expected 0010/3/1", slot_load, slot_lane[3:2], drop_count); end
    step(3);
    retire_all();
  endtask

  task automatic test_reset_mid_spawn();
    clear_rom();
    rom[0] = ent(1'b0, 2'd1, 8'd0);
    rom[1] = ent(1'b0, 2'd2, 8'd0);
    pulse_start();
    step(5);
    n_cmp++; if (slot_load !== 4'b0010 || chart_addr !== 9'd1) begin n_bad++; $display("FAIL mid_spawn: load=%b addr=%0d expected 0010/1", slot_load, chart_addr); end
    Reset = 1'b0;
    #1;
    n_cmp++; if ({slot_load, slot_active, slot_lane} !== 16'h0 || {chart_addr, drop_count, busy} !== 18'h0) begin n_bad++; $display("FAIL mid_reset: load=%b active=%b lane=%h addr=%0d drop=%0d busy=%b expected all 0", slot_load, slot_active, slot_lane, chart_addr, drop_count, busy); end
    n_cmp++; if (startY !== 13'd0) begin n_bad++; $display("FAIL mid_reset_starty: got %0d expected 0", startY); end
    Reset = 1'b1;
    step(1);
    pulse_start();
    n_cmp++; if (chart_addr !== 9'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL replay_fetch: addr=%0d busy=%b expected 0/1", chart_addr, busy); end
    step(2);
    n_cmp++; if (slot_load !== 4'b0001 || slot_lane[1:0] !== 2'd1) begin n_bad++; $display("FAIL replay_load: load=%b lane=%0d expected 0001/1", slot_load, slot_lane[1:0]); end
    step(4);
    retire_all();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < DEPTH; i++) rom[i] = ent(1'b0, 2'(i % 4), 8'd0);
    pulse_start();
    step(1600);
    n_cmp++; if (drop_count !== 8'd255) begin n_bad++; $display("FAIL sat_count: got %0d expected 255", drop_count); end
    n_cmp++; if (chart_addr !== 9'd511 || busy !== 1'b1 || slot_active !== 4'b1111) begin n_bad++; $display("FAIL sat_end: addr=%0d busy=%b active=%b expected 511/1/1111", chart_addr, busy, slot_active); end
    for (int i = 0; i < 3; i++) yv[i] = 13'd480;
    step(3);
    n_cmp++; if (busy !== 1'b1 || slot_active !== 4'b1000) begin n_bad++; $display("FAIL sat_wait: busy=%b active=%b expected 1/1000", busy, slot_active); end
    yv[3] = 13'd480;
    step(1);
    n_cmp++; if (slot_active !== 4'b0000) begin n_bad++; $display("FAIL sat_last_retire: got %b expected 0000", slot_active); end
    step(1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sat_idle: got %b expected 0", busy); end
    for (int i = 0; i < NS; i++) yv[i] = 13'd0;
  endtask

  initial begin
    test_reset();
    test_basic_chart();
    test_drops();
    test_retire_reuse();
    test_retire_spawn_same_cycle();
    test_reset_mid_spawn();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
